// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Register-file snapshot/restore controller: BACKUP copies the RF into a shadow array three words per cycle,
// RECOVER writes it back two words per cycle. Optional shadow parity via `CV32E40P_RF_RECOVERY_PARITY_EN.
module cv32e40p_rf_recovery_ctrl #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        backup_start_i,
    input  logic        recover_start_i,
    output logic        busy_o,
    output logic        snapshot_valid_o,
    output logic        backup_done_o,
    output logic        recover_done_o,
    output logic        recover_err_o,
    output logic        parity_err_o,
    output logic        regfile_backup_o,
    output logic [5:0]  regfile_raddr_ra_o,
    output logic [5:0]  regfile_raddr_rb_o,
    output logic [5:0]  regfile_raddr_rc_o,
    input  logic [31:0] regfile_rdata_ra_i,
    input  logic [31:0] regfile_rdata_rb_i,
    input  logic [31:0] regfile_rdata_rc_i,
    output logic        recover_o,
    output logic [5:0]  regfile_waddr_a_o,
    output logic [5:0]  regfile_waddr_b_o,
    output logic [31:0] regfile_wdata_a_o,
    output logic [31:0] regfile_wdata_b_o,
    output logic        regfile_we_a_o,
    output logic        regfile_we_b_o
);

    typedef enum logic [1:0] {IDLE, BACKUP, RECOVER} state_t;

    localparam int unsigned AW      = $clog2(NUM_REGS);
    localparam logic [5:0]  BK_LAST = 6'((NUM_REGS + 2) / 3 - 1);
    localparam logic [5:0]  RC_LAST = 6'(NUM_REGS / 2 - 1);

    state_t      state;
    logic [5:0]  idx;
    logic [31:0] shadow [NUM_REGS];

    logic [7:0]  rd_addr [3];
    logic        rd_ok   [3];
    logic [31:0] rd_data [3];
    logic [AW-1:0] wa, wb;

    assign rd_data[0] = regfile_rdata_ra_i;
    assign rd_data[1] = regfile_rdata_rb_i;
    assign rd_data[2] = regfile_rdata_rc_i;

    always_comb begin
        for (int unsigned j = 0; j < 3; j++) begin
            rd_addr[j] = 8'(idx) * 8'd3 + 8'(j);
            rd_ok[j]   = rd_addr[j] < 8'(NUM_REGS);
        end
        wa = {idx[AW-2:0], 1'b0};
        wb = {idx[AW-2:0], 1'b1};
    end

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            idx              <= '0;
            snapshot_valid_o <= 1'b0;
            backup_done_o    <= 1'b0;
            recover_done_o   <= 1'b0;
            recover_err_o    <= 1'b0;
        end else begin
            backup_done_o  <= 1'b0;
            recover_done_o <= 1'b0;
            recover_err_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (recover_start_i) begin
                        if (snapshot_valid_o) begin
                            state <= RECOVER;
                            idx   <= '0;
                        end else begin
                            recover_err_o <= 1'b1;
                        end
                    end else if (backup_start_i) begin
                        state            <= BACKUP;
                        idx              <= '0;
                        snapshot_valid_o <= 1'b0;
                    end
                end
                BACKUP: begin
                    if (idx == BK_LAST) begin
                        state            <= IDLE;
                        idx              <= '0;
                        snapshot_valid_o <= 1'b1;
                        backup_done_o    <= 1'b1;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                RECOVER: begin
                    if (idx == RC_LAST) begin
                        state          <= IDLE;
                        idx            <= '0;
                        recover_done_o <= 1'b1;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
    logic shadow_par [NUM_REGS];
    logic par_bad;
    logic bk_enter;

    assign bk_enter = (state == IDLE) && !recover_start_i && backup_start_i;
    assign par_bad  = (state == RECOVER) &&
                      (((^shadow[wa]) != shadow_par[wa]) || ((^shadow[wb]) != shadow_par[wb]));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       parity_err_o <= 1'b0;
        else if (bk_enter) parity_err_o <= 1'b0;
        else if (par_bad)  parity_err_o <= 1'b1;
    end
`else
    assign parity_err_o = 1'b0;
`endif

    // Shadow array is deliberately unreset; only snapshot_valid_o qualifies it.
    always_ff @(posedge clk_i) begin
        if (state == BACKUP) begin
            for (int unsigned j = 0; j < 3; j++) begin
                if (rd_ok[j]) begin
                    shadow[rd_addr[j][AW-1:0]] <= rd_data[j];
`ifdef CV32E40P_RF_RECOVERY_PARITY_EN
                    shadow_par[rd_addr[j][AW-1:0]] <= ^rd_data[j];
`endif
                end
            end
        end
    end

    always_comb begin
        regfile_backup_o   = 1'b0;
        regfile_raddr_ra_o = '0;
        regfile_raddr_rb_o = '0;
        regfile_raddr_rc_o = '0;
        recover_o          = 1'b0;
        regfile_waddr_a_o  = '0;
        regfile_waddr_b_o  = '0;
        regfile_wdata_a_o  = '0;
        regfile_wdata_b_o  = '0;
        regfile_we_a_o     = 1'b0;
        regfile_we_b_o     = 1'b0;
        case (state)
            BACKUP: begin
                regfile_backup_o   = 1'b1;
                regfile_raddr_ra_o = rd_ok[0] ? rd_addr[0][5:0] : 6'd0;
                regfile_raddr_rb_o = rd_ok[1] ? rd_addr[1][5:0] : 6'd0;
                regfile_raddr_rc_o = rd_ok[2] ? rd_addr[2][5:0] : 6'd0;
            end
            RECOVER: begin
                recover_o         = 1'b1;
                regfile_waddr_a_o = 6'(wa);
                regfile_waddr_b_o = 6'(wb);
                regfile_wdata_a_o = shadow[wa];
                regfile_wdata_b_o = shadow[wb];
                regfile_we_a_o    = 1'b1;
                regfile_we_b_o    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/cv32e40p_rf_recovery_ctrl.md
CV32E40P_RF_RECOVERY_CTRL -- requirements
Module: cv32e40p_rf_recovery_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of register-file entries snapshotted (legal: 32, 64).
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  async reset, active low.
REQ-003 SHALL have ports: backup_start_i  in  1  snapshot request; recover_start_i  in  1  restore request.
REQ-004 SHALL have ports: busy_o  out  1  FSM not IDLE; snapshot_valid_o  out  1  complete snapshot held; backup_done_o, recover_done_o  out  1  one-cycle completion pulses; recover_err_o  out  1  one-cycle pulse, recover requested with no snapshot; parity_err_o  out  1  sticky shadow parity error.
REQ-005 SHALL have RF read-side ports: regfile_backup_o  out  1; regfile_raddr_ra_o, _rb_o, _rc_o  out  6; regfile_rdata_ra_i, _rb_i, _rc_i  in  32, combinational RF read data.
REQ-006 SHALL have RF write-side ports: recover_o  out  1; regfile_waddr_a_o, regfile_waddr_b_o  out  6; regfile_wdata_a_o, regfile_wdata_b_o  out  32; regfile_we_a_o, regfile_we_b_o  out  1.

Function
REQ-007 SHALL implement states IDLE, BACKUP, RECOVER; busy_o = (state != IDLE).
REQ-008 IDLE: recover_start_i with snapshot_valid_o=1 -> RECOVER; recover_start_i with snapshot_valid_o=0 -> stay IDLE, pulse recover_err_o next cycle; else backup_start_i -> BACKUP. Recover has priority when both asserted.
REQ-009 Start inputs SHALL be ignored while busy_o=1.
REQ-010 Entering BACKUP SHALL clear snapshot_valid_o and the index counter to 0.
REQ-011 BACKUP cycle k: regfile_backup_o=1, raddr_ra/rb/rc = 3k, 3k+1, 3k+2; each in-range word captured into shadow at the clock edge; out-of-range slots drive address 0 and are not stored.
REQ-012 BACKUP SHALL last ceil(NUM_REGS/3) cycles (11 for 32, 22 for 64); then IDLE, snapshot_valid_o=1, backup_done_o high for the first IDLE cycle.
REQ-013 RECOVER cycle k: recover_o=1, waddr_a=2k, waddr_b=2k+1, we_a=we_b=1, wdata from shadow; ports A and B never address the same entry.
REQ-014 RECOVER SHALL last NUM_REGS/2 cycles (16 for 32); then IDLE, recover_done_o high for the first IDLE cycle; snapshot_valid_o stays 1.
REQ-015 Outside their states, regfile_backup_o, recover_o, we_a/we_b SHALL be 0 and all addresses/wdata 0.
REQ-016 Shadow storage SHALL be NUM_REGS x 32 flops without reset; contents meaningful only when snapshot_valid_o=1.

Reset
REQ-017 rst_ni low SHALL asynchronously force IDLE, counter 0, and all outputs 0, including snapshot_valid_o and parity_err_o.
REQ-018 Reset mid-BACKUP or mid-RECOVER SHALL abort with no further RF writes and snapshot_valid_o=0 after release.

Configuration
REQ-019 Macro CV32E40P_RF_RECOVERY_PARITY_EN defined: one even-parity bit stored per shadow word at capture, checked on each RECOVER read; any mismatch sets parity_err_o (sticky, cleared on entering BACKUP); data is still written.
REQ-020 Macro undefined: no parity storage, parity_err_o tied 0; port list identical.

Verification
REQ-021 RF model x[i]=0x1000_0000+i, NUM_REGS=32, pulse backup_start_i -> busy 11 cycles, addresses 0..32 step 3, backup_done_o one cycle, snapshot_valid_o=1.
REQ-022 After REQ-021, overwrite RF with 0xDEADBEEF, pulse recover_start_i -> 16 write cycles, pairs (0,1)..(30,31), RF restored to 0x1000_0000+i, recover_done_o one cycle.
REQ-023 After reset, pulse recover_start_i -> recover_err_o one cycle, busy_o stays 0, no write enables.
REQ-024 backup_start_i and recover_start_i same cycle with valid snapshot -> RECOVER; backup_start_i during RECOVER cycle 5 -> ignored, RECOVER completes at 16 cycles.
REQ-025 rst_ni low at BACKUP cycle 6 -> outputs 0 immediately, snapshot_valid_o=0 after release; subsequent recover_start_i -> recover_err_o.
REQ-026 With CV32E40P_RF_RECOVERY_PARITY_EN, force flip of shadow word 7 bit 3 before RECOVER -> parity_err_o set and held; next backup_start_i clears it.
